// File: rtl/urv_iram_loader.sv
// Loads a byte stream into instruction RAM, little-endian word assembly,
// with optional read-back verification of every written word.
`timescale 1ns/1ps
module urv_iram_loader #(
    parameter int unsigned g_size   = 65536,
    parameter int unsigned g_verify = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [31:0] base_addr_i,
    input  logic [31:0] len_i,
    input  logic        abort_i,
    input  logic [7:0]  byte_i,
    input  logic        byte_valid_i,
    output logic        byte_ready_o,
    output logic        ram_en_o,
    output logic        ram_we_o,
    output logic [31:0] ram_addr_o,
    output logic [3:0]  ram_bwe_o,
    output logic [31:0] ram_d_o,
    input  logic [31:0] ram_q_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o,
    output logic [31:0] err_addr_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_WRITE,
        S_READ,
        S_CHECK,
        S_DONE
    } state_t;

    localparam logic [31:0] ADDR_MASK = 32'(g_size - 1);

    state_t      state_q, state_d;
    logic [31:0] base_q;
    logic [31:0] len_q;
    logic [31:0] idx_q;
    logic [31:0] word_q;
    logic [1:0]  bcnt_q;
    logic        error_q;
    logic [31:0] err_addr_q;

    logic [31:0] cur_addr;
    logic [31:0] idx_next;
    logic        last_word;
    logic        mismatch;

    assign cur_addr  = (base_q + (idx_q << 2)) & ADDR_MASK;
    assign idx_next  = idx_q + 32'd1;
    assign last_word = (idx_next == len_q);
    assign mismatch  = (ram_q_i != word_q);

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort overrides every other transition
    always_comb begin
        state_d = state_q;
        if (state_q != S_IDLE && abort_i) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_d = (len_i == 32'd0) ? S_DONE : S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    if (byte_valid_i && bcnt_q == 2'd3) begin
                        state_d = S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (g_verify != 0) begin
                        state_d = S_READ;
                    end else begin
                        state_d = last_word ? S_DONE : S_COLLECT;
                    end
                end
                S_READ: begin
                    state_d = S_CHECK;
                end
                S_CHECK: begin
                    if (mismatch || last_word) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_COLLECT;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Load context, byte assembly, word index and sticky error capture
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            base_q     <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            word_q     <= '0;
            bcnt_q     <= '0;
            error_q    <= 1'b0;
            err_addr_q <= '0;
        end else if (state_q == S_IDLE) begin
            if (start_i) begin
                base_q  <= base_addr_i & 32'hFFFF_FFFC;
                len_q   <= len_i;
                idx_q   <= '0;
                bcnt_q  <= '0;
                error_q <= 1'b0;
                if (len_i != 32'd0) begin
                    err_addr_q <= '0;
                end
            end
        end else if (!abort_i) begin
            if (state_q == S_COLLECT && byte_valid_i) begin
                word_q[{bcnt_q, 3'b000} +: 8] <= byte_i;
                bcnt_q <= bcnt_q + 2'd1;
            end
            if (state_q == S_WRITE && g_verify == 0) begin
                idx_q <= idx_next;
            end
            if (state_q == S_CHECK) begin
                if (mismatch) begin
                    error_q    <= 1'b1;
                    err_addr_q <= cur_addr;
                end else begin
                    idx_q <= idx_next;
                end
            end
        end
    end

    // Outputs decoded from the current state only
    always_comb begin
        byte_ready_o = 1'b0;
        ram_en_o     = 1'b0;
        ram_we_o     = 1'b0;
        ram_bwe_o    = 4'h0;
        ram_addr_o   = '0;
        ram_d_o      = '0;
        busy_o       = (state_q != S_IDLE);
        done_o       = 1'b0;
        unique case (state_q)
            S_COLLECT: byte_ready_o = 1'b1;
            S_WRITE: begin
                ram_en_o   = 1'b1;
                ram_we_o   = 1'b1;
                ram_bwe_o  = 4'hF;
                ram_addr_o = cur_addr;
                ram_d_o    = word_q;
            end
            S_READ: begin
                ram_en_o   = 1'b1;
                ram_addr_o = cur_addr;
            end
            S_DONE:  done_o = 1'b1;
            default: ;
        endcase
    end

    assign error_o    = error_q;
    assign err_addr_o = err_addr_q;

endmodule

// File: tb/tb_urv_iram_loader.sv
// Scoreboard bench for urv_iram_loader: verifying 64 KiB instance plus a
// 16 KiB write-only instance for the address wrap case.
`timescale 1ns/1ps
module tb_urv_iram_loader;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Verifying instance
    logic        start = 0, abort = 0, bval = 0;
    logic [31:0] base = 0, len = 0;
    logic [7:0]  byt = 0;
    logic        ready, ram_en, ram_we, busy, done, err;
    logic [31:0] ram_addr, ram_d, eaddr;
    logic [31:0] ram_q = 0;
    logic [3:0]  ram_bwe;

    // Write-only 16 KiB instance
    logic        b_start = 0, b_abort = 0, b_bval = 0;
    logic [31:0] b_base = 0, b_len = 0;
    logic [7:0]  b_byt = 0;
    logic        b_ready, b_en, b_we, b_busy, b_done, b_err;
    logic [31:0] b_addr, b_d, b_eaddr;
    logic [31:0] b_q = 0;
    logic [3:0]  b_bwe;

    urv_iram_loader #(.g_size(65536), .g_verify(1)) dut_a (
        .clk_i(clk), .rst_i(rst), .start_i(start), .base_addr_i(base),
        .len_i(len), .abort_i(abort), .byte_i(byt), .byte_valid_i(bval),
        .byte_ready_o(ready), .ram_en_o(ram_en), .ram_we_o(ram_we),
        .ram_addr_o(ram_addr), .ram_bwe_o(ram_bwe), .ram_d_o(ram_d),
        .ram_q_i(ram_q), .busy_o(busy), .done_o(done), .error_o(err),
        .err_addr_o(eaddr)
    );

    urv_iram_loader #(.g_size(16384), .g_verify(0)) dut_b (
        .clk_i(clk), .rst_i(rst), .start_i(b_start), .base_addr_i(b_base),
        .len_i(b_len), .abort_i(b_abort), .byte_i(b_byt), .byte_valid_i(b_bval),
        .byte_ready_o(b_ready), .ram_en_o(b_en), .ram_we_o(b_we),
        .ram_addr_o(b_addr), .ram_bwe_o(b_bwe), .ram_d_o(b_d),
        .ram_q_i(b_q), .busy_o(b_busy), .done_o(b_done), .error_o(b_err),
        .err_addr_o(b_eaddr)
    );

    int vecs = 0;
    int miss = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        vecs++;
        miss++;
        $display("FAIL %s: event did not occur as required", name);
    endtask

    typedef struct { logic [31:0] a; logic [31:0] d; } wr_t;
    typedef struct { logic e; logic [31:0] ea; bit cea; } dn_t;
    wr_t wq[$];
    wr_t bq[$];
    dn_t dq[$];
    int done_cnt = 0;
    int b_done_cnt = 0;

    // Memory model for the verifying instance, with optional bit-0 corruption
    logic [31:0] mem [0:16383];
    bit          cor_en = 0;
    logic [31:0] cor_a = 0;

    initial forever begin
        @(posedge clk);
        if (!rst && ram_en) begin
            if (ram_we) mem[ram_addr[15:2]] <= ram_d;
            else ram_q <= mem[ram_addr[15:2]] ^
                          ((cor_en && ram_addr == cor_a) ? 32'h1 : 32'h0);
        end
    end

    // Monitor for the verifying instance
    initial begin : mon_a
        wr_t         e;
        dn_t         de;
        logic [31:0] last_wa;
        last_wa = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (ram_en && ram_we) begin
                    if (wq.size() == 0) begin
                        vecs++; miss++;
                        $display("FAIL unexpected_write: got addr %h data %h required none", ram_addr, ram_d);
                    end else begin
                        e = wq.pop_front();
                        chk("wr_addr", ram_addr, e.a);
                        chk("wr_data", ram_d, e.d);
                        chk("wr_bwe", {28'b0, ram_bwe}, 32'hF);
                    end
                    last_wa = ram_addr;
                end
                if (ram_en && !ram_we) begin
                    chk("rd_addr", ram_addr, last_wa);
                    chk("rd_bwe", {28'b0, ram_bwe}, 32'h0);
                end
                if (done) begin
                    done_cnt++;
                    if (dq.size() == 0) begin
                        vecs++; miss++;
                        $display("FAIL unexpected_done: got done=1 required 0");
                    end else begin
                        de = dq.pop_front();
                        chk("done_err", {31'b0, err}, {31'b0, de.e});
                        if (de.cea) chk("done_eaddr", eaddr, de.ea);
                    end
                end
            end
        end
    end

    // Monitor for the write-only instance
    initial begin : mon_b
        wr_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (b_en && b_we) begin
                    if (bq.size() == 0) begin
                        vecs++; miss++;
                        $display("FAIL b_unexpected_write: got addr %h required none", b_addr);
                    end else begin
                        e = bq.pop_front();
                        chk("b_wr_addr", b_addr, e.a);
                        chk("b_wr_data", b_d, e.d);
                    end
                end
                if (b_en && !b_we) fail("b_no_read");
                if (b_done) begin
                    b_done_cnt++;
                    chk("b_done_err", {31'b0, b_err}, 32'h0);
                end
            end
        end
    end

    // Offer bytes with random gaps; junk start pulses must be ignored while busy
    task automatic send(input bit sel, input logic [7:0] b[$]);
        for (int i = 0; i < b.size(); i++) begin
            int  gap;
            bit  ok;
            int  t;
            gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            repeat (gap) @(posedge clk);
            #1;
            if (sel) begin
                b_byt = b[i]; b_bval = 1;
            end else begin
                byt = b[i]; bval = 1;
                start = ($urandom_range(0, 3) == 0);
                base = $urandom; len = 0;
            end
            ok = 0; t = 0;
            while (!ok && t < 40) begin
                @(negedge clk);
                if (sel ? b_ready : ready) ok = 1;
                @(posedge clk);
                t++;
            end
            #1;
            bval = 0; b_bval = 0; start = 0;
            if (!ok) fail("byte_accept_timeout");
        end
    endtask

    function automatic logic [31:0] waddr(input logic [31:0] bs, input int i, input logic [31:0] sz);
        return ((bs & 32'hFFFF_FFFC) + 32'(4 * i)) % sz;
    endfunction

    // One load on the verifying instance; k = word whose read-back is corrupted
    task automatic run_load(input logic [31:0] bs, input int n, input int k, input bit seq);
        logic [7:0] b[$];
        int         nw;
        int         c0;
        int         w;
        wr_t        e;
        dn_t        de;
        nw = (k >= 0 && k < n) ? k + 1 : n;
        for (int i = 0; i < nw * 4; i++)
            b.push_back(seq ? 8'((i + 1) * 8'h11) : 8'($urandom));
        for (int i = 0; i < nw; i++) begin
            e.a = waddr(bs, i, 65536);
            e.d = {b[4*i+3], b[4*i+2], b[4*i+1], b[4*i]};
            wq.push_back(e);
        end
        if (k >= 0 && k < n) begin
            cor_en = 1; cor_a = waddr(bs, k, 65536);
            de.e = 1; de.ea = cor_a; de.cea = 1;
        end else begin
            de.e = 0; de.ea = 0; de.cea = (n != 0);
        end
        dq.push_back(de);
        c0 = done_cnt;
        @(posedge clk); #1;
        start = 1; base = bs; len = n;
        @(posedge clk); #1;
        start = 0;
        if (n == 0) begin
            @(negedge clk);
            chk("len0_done_next", {31'b0, done}, 32'h1);
        end
        send(0, b);
        w = 0;
        while (done_cnt == c0 && w < 60) begin
            @(negedge clk); #1; w++;
        end
        if (done_cnt == c0) fail("done_timeout");
        cor_en = 0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] b[$];
        wr_t        e;
        int         c0;
        int         w;
        bit         seen;

        for (int i = 0; i < 16384; i++) mem[i] = 0;

        #12;
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_ready", {31'b0, ready}, 0);
        chk("rst_en", {31'b0, ram_en}, 0);
        chk("rst_we", {31'b0, ram_we}, 0);
        chk("rst_bwe", {28'b0, ram_bwe}, 0);
        chk("rst_addr", ram_addr, 0);
        chk("rst_d", ram_d, 0);
        chk("rst_done", {31'b0, done}, 0);
        chk("rst_err", {31'b0, err}, 0);
        chk("rst_eaddr", eaddr, 0);
        @(negedge clk);
        rst = 0;
        repeat (2) @(posedge clk);
        #1;

        // Byte pattern 11..88 into two words at 0x100
        run_load(32'h100, 2, -1, 1);
        chk("ok_err", {31'b0, err}, 0);

        // Read-back of 0x104 corrupted; load stops after that word
        run_load(32'h100, 3, 1, 1);
        chk("sticky_err", {31'b0, err}, 1);
        chk("sticky_eaddr", eaddr, 32'h104);

        // Zero-length load clears the error and touches no RAM
        run_load(32'h2000, 0, -1, 0);
        chk("len0_err_clr", {31'b0, err}, 0);

        // Abort after two bytes, then a fresh single-word load
        c0 = done_cnt;
        @(posedge clk); #1;
        start = 1; base = 32'h200; len = 1;
        @(posedge clk); #1;
        start = 0;
        b = {8'hA1, 8'hA2};
        send(0, b);
        abort = 1;
        @(posedge clk); #1;
        abort = 0;
        @(negedge clk);
        chk("abort_busy", {31'b0, busy}, 0);
        chk("abort_en", {31'b0, ram_en}, 0);
        chk("abort_nodone", done_cnt, c0);
        run_load(32'h200, 1, -1, 0);

        // Reset pulsed during the read-back cycle
        c0 = done_cnt;
        b = {8'h5A, 8'h6B, 8'h7C, 8'h8D};
        e.a = 32'h400; e.d = 32'h8D7C6B5A;
        wq.push_back(e);
        @(posedge clk); #1;
        start = 1; base = 32'h403; len = 1;
        @(posedge clk); #1;
        start = 0;
        send(0, b);
        seen = 0; w = 0;
        while (!seen && w < 20) begin
            @(negedge clk); w++;
            if (ram_en && !ram_we) seen = 1;
        end
        if (!seen) fail("read_cycle_timeout");
        #2 rst = 1;
        #1;
        chk("mrst_busy", {31'b0, busy}, 0);
        chk("mrst_ready", {31'b0, ready}, 0);
        chk("mrst_en", {31'b0, ram_en}, 0);
        chk("mrst_we", {31'b0, ram_we}, 0);
        chk("mrst_bwe", {28'b0, ram_bwe}, 0);
        chk("mrst_addr", ram_addr, 0);
        chk("mrst_d", ram_d, 0);
        chk("mrst_done", {31'b0, done}, 0);
        chk("mrst_err", {31'b0, err}, 0);
        chk("mrst_eaddr", eaddr, 0);
        @(posedge clk); #1;
        rst = 0;
        chk("mrst_nodone", done_cnt, c0);
        run_load(32'h500, 2, -1, 0);

        // Randomised loads with occasional read-back corruption
        for (int n = 0; n < 10; n++) begin
            int k;
            k = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 4) : -1;
            run_load($urandom, $urandom_range(0, 5), k, 0);
        end

        // Write-only 16 KiB instance wrapping past the top
        b.delete();
        for (int i = 0; i < 8; i++) b.push_back(8'($urandom));
        e.a = 32'h3FFC; e.d = {b[3], b[2], b[1], b[0]}; bq.push_back(e);
        e.a = 32'h0000; e.d = {b[7], b[6], b[5], b[4]}; bq.push_back(e);
        c0 = b_done_cnt;
        @(posedge clk); #1;
        b_start = 1; b_base = 32'h3FFC; b_len = 2;
        @(posedge clk); #1;
        b_start = 0;
        send(1, b);
        w = 0;
        while (b_done_cnt == c0 && w < 20) begin
            @(negedge clk); #1; w++;
        end
        chk("b_done_once", b_done_cnt, c0 + 1);
        repeat (3) @(posedge clk);
        #1;

        chk("wq_drained", wq.size(), 0);
        chk("dq_drained", dq.size(), 0);
        chk("bq_drained", bq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
